// File: rtl/display_scan_controller.sv
// Time-multiplexed scan of a packed BCD value onto a common-anode 7-segment bank,
// with frame-boundary double buffering and optional leading-zero blanking.
module display_scan_controller #(
  parameter int          NUM_DIGITS  = 4,
  parameter int          REFRESH_DIV = 100000,
  parameter logic [3:0]  BLANK_CODE  = 4'hF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   bcd_in,
  input  logic                      load,
  input  logic                      lz_blank,
  output logic [3:0]                digit,
  output logic [NUM_DIGITS-1:0]     anode_n,
  output logic                      frame_start,
  output logic                      pending
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]        div_cnt,  div_cnt_next;
  logic [IDX_W-1:0]        idx,      idx_next;
  logic [4*NUM_DIGITS-1:0] shadow,   shadow_next;
  logic [4*NUM_DIGITS-1:0] display,  display_next;
  logic                    pending_next;
  logic                    frame_start_next;
  logic [3:0]              digit_next;
  logic [NUM_DIGITS-1:0]   anode_n_next;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    all_zero;
  logic                    tick;
  logic                    boundary;

  // State register: every flop, including the buffers, returns to a known value on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      idx         <= '0;
      shadow      <= '0;
      display     <= '0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
      digit       <= 4'h0;
      anode_n     <= '1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      div_cnt     <= div_cnt_next;
      idx         <= idx_next;
      shadow      <= shadow_next;
      display     <= display_next;
      pending     <= pending_next;
      frame_start <= frame_start_next;
      digit       <= digit_next;
      anode_n     <= anode_n_next;
    end
  end

  // Next-state logic: divider, slot index and the shadow/display double buffer.
  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    tick             = (div_cnt == DIV_LAST);
    boundary         = tick && (idx == IDX_LAST);
    div_cnt_next     = tick ? '0 : div_cnt + 1'b1;
    idx_next         = idx;
    shadow_next      = shadow;
    display_next     = display;
    pending_next     = pending;
    frame_start_next = boundary;

    if (tick)
      idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    if (load)
      shadow_next = bcd_in;

    if (boundary) begin
      pending_next = 1'b0;
      if (load)
        display_next = bcd_in;
      else if (pending)
        display_next = shadow;
    end else if (load) begin
      pending_next = 1'b1;
    end
  end

  // Output logic from next-state values, so registered outputs track the current slot.
  always_comb begin
    all_zero = 1'b1;
    blank    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero && (display_next[4*k +: 4] == 4'h0);
      blank[k] = lz_blank && (k != 0) && all_zero;
    end

    digit_next = blank[idx_next] ? BLANK_CODE : display_next[4*int'(idx_next) +: 4];

    // Anodes stay dark for the first cycle of each slot to suppress ghosting.
    anode_n_next = '1;
    if (div_cnt_next != '0)
      anode_n_next[idx_next] = 1'b0;
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller (4 digits, 4 cycles per slot):
// table-driven load vectors plus hand-written boundary, overwrite and reset sequences.
module tb_display_scan_controller;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   bcd_in;
  logic          load;
  logic          lz_blank;
  logic [3:0]    digit;
  logic [N-1:0]  anode_n;
  logic          frame_start;
  logic          pending;

  int checks = 0;
  int errors = 0;

  // Expected per-frame digit codes, nibble i = digit shown on idx i.
  logic [15:0] sb_q[$];

  typedef struct {
    logic [15:0] bcd;
    logic        lz;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  display_scan_controller #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(DIV),
    .BLANK_CODE (4'hF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .load       (load),
    .lz_blank   (lz_blank),
    .digit      (digit),
    .anode_n    (anode_n),
    .frame_start(frame_start),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_load(input logic [15:0] v);
    bcd_in = v;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  // Advance until frame_start is seen, with a bounded budget.
  task automatic wait_frame_start();
    int n = 0;
    while (frame_start !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    check("frame_start_timeout", {31'b0, frame_start}, 32'd1);
  endtask

  // Entered at idx 0 / div 0; walks one whole frame, comparing each lit slot
  // against the oldest scoreboard entry. Leaves at the start of the next frame.
  task automatic check_frame(input string name);
    logic [15:0]  exp;
    logic [N-1:0] exp_an;
    if (sb_q.size() == 0) begin
      check({name, "_scoreboard_empty"}, 32'd0, 32'd1);
      exp = 16'h0;
    end else begin
      exp = sb_q.pop_front();
    end
    for (int i = 0; i < N; i++) begin
      step();
      exp_an = '1;
      exp_an[i] = 1'b0;
      check({name, "_anode"}, {28'b0, anode_n}, {28'b0, exp_an});
      check({name, "_digit"}, {28'b0, digit}, {28'b0, exp[4*i +: 4]});
      steps(DIV - 1);
    end
  endtask

  initial begin
    vecs[0] = '{bcd: 16'h1234, lz: 1'b0, exp: 16'h1234};
    vecs[1] = '{bcd: 16'h0042, lz: 1'b1, exp: 16'hFF42};
    vecs[2] = '{bcd: 16'h0000, lz: 1'b1, exp: 16'hFFF0};
    vecs[3] = '{bcd: 16'h0402, lz: 1'b1, exp: 16'hF402};
    vecs[4] = '{bcd: 16'h00A0, lz: 1'b1, exp: 16'hFFA0};
    vecs[5] = '{bcd: 16'h0000, lz: 1'b0, exp: 16'h0000};

    rst = 1'b1; bcd_in = '0; load = 1'b0; lz_blank = 1'b0;
    steps(2);
    check("rst_anode", {28'b0, anode_n}, 32'hF);
    check("rst_digit", {28'b0, digit}, 32'h0);
    check("rst_pending", {31'b0, pending}, 32'd0);
    check("rst_frame_start", {31'b0, frame_start}, 32'd0);
    #2 rst = 1'b0;

    // Free-running scan with an empty display.
    for (int c = 1; c <= 16; c++) begin
      logic [N-1:0] exp_an;
      step();
      exp_an = '1;
      if (c % DIV != 0) exp_an[(c / DIV) % N] = 1'b0;
      check("scan_anode", {28'b0, anode_n}, {28'b0, exp_an});
      check("scan_digit", {28'b0, digit}, 32'h0);
      check("scan_frame_start", {31'b0, frame_start}, (c == 16) ? 32'd1 : 32'd0);
    end

    // Table-driven loads applied mid-frame.
    for (int v = 0; v < 6; v++) begin
      lz_blank = vecs[v].lz;
      steps(5);
      pulse_load(vecs[v].bcd);
      check("vec_pending_set", {31'b0, pending}, 32'd1);
      sb_q.push_back(vecs[v].exp);
      wait_frame_start();
      check("vec_pending_clear", {31'b0, pending}, 32'd0);
      check_frame("vec");
    end

    // Current frame keeps old content until the boundary.
    lz_blank = 1'b0;
    steps(2);
    pulse_load(16'h9999);
    step();
    check("old_frame_digit", {28'b0, digit}, 32'h0);
    wait_frame_start();
    sb_q.push_back(16'h9999);
    check_frame("transfer");

    // lz_blank dropped mid-frame affects the following slot.
    lz_blank = 1'b1;
    steps(2);
    pulse_load(16'h0042);
    wait_frame_start();
    steps(DIV * 2 + 1);
    check("lz_idx2_blank", {28'b0, digit}, 32'hF);
    lz_blank = 1'b0;
    steps(DIV);
    check("lz_idx3_unblank", {28'b0, digit}, 32'h0);
    wait_frame_start();
    steps(DIV * N);

    // Load exactly on the boundary tick.
    steps(DIV * N - 1);
    bcd_in = 16'h5678;
    load   = 1'b1;
    step();
    load   = 1'b0;
    check("bnd_frame_start", {31'b0, frame_start}, 32'd1);
    check("bnd_pending", {31'b0, pending}, 32'd0);
    sb_q.push_back(16'h5678);
    check_frame("boundary_load");
    check("bnd_pending_after", {31'b0, pending}, 32'd0);

    // Two loads in one frame: last wins.
    steps(2);
    pulse_load(16'h1111);
    steps(3);
    pulse_load(16'h2222);
    sb_q.push_back(16'h2222);
    wait_frame_start();
    check_frame("overwrite");

    // Asynchronous reset mid-slot at idx 2 with a load pending.
    pulse_load(16'h9999);
    steps(DIV * 2);
    check("pre_rst_anode", {28'b0, anode_n}, 32'hB);
    check("pre_rst_pending", {31'b0, pending}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_anode", {28'b0, anode_n}, 32'hF);
    check("async_rst_digit", {28'b0, digit}, 32'h0);
    check("async_rst_pending", {31'b0, pending}, 32'd0);
    #1 rst = 1'b0;
    step();
    check("restart_anode", {28'b0, anode_n}, 32'hE);
    check("restart_digit", {28'b0, digit}, 32'h0);
    wait_frame_start();
    sb_q.push_back(16'h0000);
    check_frame("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Time-multiplexes a packed multi-digit BCD value onto a common-anode 7-segment bank. It sits directly upstream of the per-digit segment decoder. Each cycle it presents one 4-bit digit code to the decoder and drives the matching active-low anode enable. Values are double-buffered so that updates land only on frame boundaries, which prevents tearing. Optional leading-zero blanking is supported.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (range 2..8); digit 0 is least significant.
REFRESH_DIV, 100000, clock cycles per digit slot (minimum 2).
BLANK_CODE, 4'hF, code emitted for a blanked digit; the decoder renders any code above 9 as blank.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
bcd_in  input  4*NUM_DIGITS  packed digits; [3:0] is digit 0
load  input  1  single-cycle strobe; capture bcd_in
lz_blank  input  1  enable leading-zero blanking (level, sampled every cycle)
digit  output  4  code to the segment decoder
anode_n  output  NUM_DIGITS  active-low digit enables; one-hot-low or all ones
frame_start  output  1  one-cycle pulse when the scan wraps to digit 0
pending  output  1  a loaded value is waiting for the next frame boundary

Behaviour:
- Single clock (clk); reset is asynchronous and active-high (rst).
- Reset state:
  - div_cnt=0, idx=0.
  - Shadow and display registers all zero; pending=0, frame_start=0.
  - anode_n all ones; digit=4'h0.
- Divider:
  - div_cnt counts 0..REFRESH_DIV-1.
  - tick = (div_cnt==REFRESH_DIV-1).
  - On tick: div_cnt<=0 and idx<=idx+1, wrapping NUM_DIGITS-1 -> 0.
- Frame boundary = tick while idx==NUM_DIGITS-1.
  - frame_start is registered and is high for exactly the first cycle with idx==0 after a wrap.
  - frame_start does not pulse out of reset.
- Outputs:
  - digit and anode_n are flops loaded from next-state values, so in any cycle they reflect the current idx/div_cnt.
  - anode_n is all ones while div_cnt==0 (one-cycle anti-ghost gap per slot).
  - Otherwise anode_n[idx]=0 and all other bits are 1.
  - digit = display nibble idx, or BLANK_CODE if that digit is blanked.
  - digit changes at the slot boundary even while anode_n is all ones.
- Load and transfer:
  - On load, bcd_in goes to shadow and pending<=1.
  - At a frame boundary with pending=1: display<=shadow and pending<=0.
  - load coincident with a frame boundary: bcd_in goes to both shadow and display; pending stays/becomes 0.
  - Repeated loads before a boundary overwrite shadow; the last one wins.
- Leading-zero blanking, evaluated on display contents:
  - Digit k is blanked iff lz_blank=1, k>0, and digits NUM_DIGITS-1..k are all 4'h0.
  - Digit 0 is never blanked.
  - Non-BCD nibbles (A..F) pass through unchanged and count as non-zero.
- Reset mid-scan: all state returns immediately to the reset values; display content is lost (0000).
- No combinational path from inputs to outputs.

Test Plan:
1. Reset, then run with NUM_DIGITS=4, REFRESH_DIV=4, no load -> anode_n cycles 1111,1110,1110,1110,1111,1101,... through 0111. digit is 0 in all slots. frame_start pulses once per 16 cycles, in the first cycle of idx 0.
2. Load bcd_in=16'h1234 mid-frame, lz_blank=0 -> pending=1 until the boundary, then 0. The following frame shows digits 4,3,2,1 on idx 0..3. The current frame still shows 0s.
3. Load 16'h0042, lz_blank=1 -> per idx 0..3: digit 2,4,F,F. Then load 16'h0000 -> digit 0,F,F,F. Then load 16'h0402 -> digit 2,0,4,F. Toggling lz_blank=0 mid-frame changes the next slot's digit to 0 where it was F.
4. Pulse load (16'h5678) in the exact boundary-tick cycle -> the new frame shows 8,7,6,5 immediately, and pending never rises.
5. Load 16'h1111 then 16'h2222 in the same frame -> the next frame shows 2,2,2,2.
6. Assert rst asynchronously mid-slot at idx=2 -> anode_n=1111, digit=0, pending=0 with no clock edge. After release, the scan restarts at idx 0 with display 0000.
